axi_wr_req_buffer: RTL
======================

// Module: axi_wr_req_buffer
// PURPOSE
//  Upstream feeder for the systemverilog_ip AXI-like write port, in the clk_a domain.
//  Queues write requests (addr/data/strb) from a simple valid/ready source in a small FIFO.
//  Issues each request on the single-valid AXI-like write port: one awvalid, separate awready/wready.
//  Tracks completion of both handshakes, times out stuck transfers, and counts completed writes.
// PARAMETERS
//  ADDR_WIDTH      16   request/AXI address width
//  DATA_WIDTH      32   request/AXI data width; multiple of 8
//  FIFO_DEPTH      4    request queue entries; power of 2, >=2
//  TIMEOUT_CYCLES  255  max cycles awvalid stays high before abort; 0 = timeout disabled
// PORTS
//  clk_a        in   1             clock
//  reset_n      in   1             synchronous active-low reset
//  req_valid    in   1             request valid
//  req_ready    out  1             request accepted when req_valid && req_ready
//  req_addr     in   ADDR_WIDTH    request address
//  req_data     in   DATA_WIDTH    request write data
//  req_strb     in   DATA_WIDTH/8  request byte strobes
//  axi_awvalid  out  1             address+data valid, to IP axi_awvalid
//  axi_awaddr   out  ADDR_WIDTH    to IP axi_awaddr
//  axi_wdata    out  DATA_WIDTH    to IP axi_wdata
//  axi_wstrb    out  DATA_WIDTH/8  to IP axi_wstrb
//  axi_awready  in   1             address accepted, from IP
//  axi_wready   in   1             data accepted, from IP
//  fifo_level   out  clog2(FIFO_DEPTH)+1  queued entries, including the one being issued
//  busy         out  1             FSM not IDLE or fifo_level!=0
//  wr_done      out  1             1-cycle pulse per completed write
//  err_timeout  out  1             1-cycle pulse per aborted write
//  done_count   out  16            completed writes, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: while reset_n=0 at an edge, all outputs go to 0, including req_ready.
//   FIFO is flushed; FSM goes to IDLE; aw_done/w_done/timer are cleared.
//   Reset mid-transfer discards the transfer and all queued entries; no wr_done/err_timeout pulse.
//  req_ready is registered: next value = (next fifo_level < FIFO_DEPTH). It is 1 in the first cycle after reset.
//  Push: req_valid && req_ready at edge k writes the FIFO. Pops are not credited to req_ready in the same cycle.
//  FSM states: IDLE, ISSUE.
//   IDLE: if FIFO is non-empty at an edge, load axi_awaddr/wdata/wstrb from the head, set axi_awvalid=1,
//    and clear aw_done, w_done and the timer; go to ISSUE.
//    Latency: a request accepted into an empty FIFO at edge k gives axi_awvalid=1 after edge k+2.
//   ISSUE: axi_awvalid and the address/data/strobe outputs are held stable.
//    Each edge: aw_done |= axi_awready; w_done |= axi_wready; timer++.
//    Complete when (aw_done|axi_awready) && (w_done|axi_wready). Both readies may arrive in the same cycle or in any order.
//    On complete: axi_awvalid<=0, pop head, wr_done pulse, done_count++ (saturating), go to IDLE.
//    Timeout (TIMEOUT_CYCLES!=0): if not completing and timer==TIMEOUT_CYCLES-1,
//     then axi_awvalid<=0, pop head, err_timeout pulse, done_count unchanged, go to IDLE.
//    If completion and timeout fall on the same edge, completion wins.
//    A repeated axi_awready or axi_wready after its done flag is set is ignored.
//  axi_awvalid drops for at least 1 cycle (IDLE) between transfers. Max throughput is 1 write per 2 cycles.
//  After axi_awvalid drops, the address/data/strobe outputs keep their last value.
//  Push and pop on the same edge: fifo_level is unchanged; pointers wrap modulo FIFO_DEPTH.
//  Requests issue in strict FIFO order.
// TESTING
//  1 Push addr 16'h0010, data 32'hDEADBEEF, strb 4'hF; awready=wready=1 -> awvalid high exactly 1 cycle, outputs match, wr_done x1, done_count=1.
//  2 Push 1 request; wready in ISSUE cycle 2, awready in cycle 5 -> awvalid high exactly 5 cycles, outputs stable, 1 wr_done.
//  3 Hold readies low (TIMEOUT_CYCLES=0); offer 5 requests -> req_ready=0 once level=4, 5th held.
//    Release readies -> 5 writes in push order, each with a 1-cycle awvalid gap.
//  4 TIMEOUT_CYCLES=8, readies never high, 2 queued -> awvalid high 8 cycles, err_timeout x1, level 2->1.
//    Second entry then issues; done_count=0.
//  5 3 entries queued, reset_n=0 for 1 edge during ISSUE -> awvalid=0, fifo_level=0, done_count=0, no pulses.
//    req_ready=1 the next cycle.
//  6 FIFO full, completion pop and req_valid=1 on the same edge -> no push that edge (req_ready=0), level 4->3, req_ready=1 the next cycle.

Source files
------------

// File: rtl/axi_wr_req_buffer.sv
// Generic synchronous FIFO that exposes the head entry and the current occupancy.
// Latency: an entry written at edge k is readable at the head from edge k on (combinational head read).
// Backpressure: none internally; the caller must never push when full or pop when empty.
module axi_wr_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign head_dat = mem[rd_ptr];

    // Storage array; no reset needed because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; level tracks push/pop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// Queues write requests and issues them one at a time on a single-valid AXI-like write port.
// Latency: request accepted into an empty queue at edge k drives axi_awvalid after edge k+2; 1 write per 2 cycles max.
// Backpressure: req_ready is registered and drops once the queue (including the in-flight entry) is full.
module axi_wr_req_buffer #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk_a,
    input  logic                          reset_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0]         req_data,
    input  logic [DATA_WIDTH/8-1:0]       req_strb,
    output logic                          axi_awvalid,
    output logic [ADDR_WIDTH-1:0]         axi_awaddr,
    output logic [DATA_WIDTH-1:0]         axi_wdata,
    output logic [DATA_WIDTH/8-1:0]       axi_wstrb,
    input  logic                          axi_awready,
    input  logic                          axi_wready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          wr_done,
    output logic                          err_timeout,
    output logic [15:0]                   done_count
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LW     = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 2);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_W-1:0]     strb;
    } req_t;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t           state;
    req_t             push_req;
    req_t             head_req;
    logic             push;
    logic             pop;
    logic             complete;
    logic             timeout;
    logic             head_ok;
    logic             aw_done;
    logic             w_done;
    logic [TMR_W-1:0] timer;
    logic [LW-1:0]    level_d;
    logic [LW-1:0]    level_next;

    assign push_req = '{addr: req_addr, data: req_data, strb: req_strb};
    assign push     = req_valid && req_ready;
    assign complete = (state == ISSUE) && (aw_done || axi_awready) && (w_done || axi_wready);
    assign timeout  = (state == ISSUE) && !complete && (TIMEOUT_CYCLES != 0)
                      && (timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign pop      = complete || timeout;
    // The head is only issued once it has sat in the queue for a full cycle, which
    // gives the two-edge accept-to-issue latency for a request entering an empty queue.
    assign head_ok  = (fifo_level != '0) && (level_d != '0);
    assign busy     = (state != IDLE) || (fifo_level != '0);

    axi_wr_req_fifo #(
        .WIDTH (ADDR_WIDTH + DATA_WIDTH + STRB_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_a),
        .reset_n  (reset_n),
        .push     (push),
        .push_dat (push_req),
        .pop      (pop),
        .head_dat (head_req),
        .level    (fifo_level)
    );

    // Occupancy after this edge; ready is derived from it so pops never free a slot early.
    always_comb begin
        level_next = fifo_level;
        case ({push, pop})
            2'b10:   level_next = fifo_level + 1'b1;
            2'b01:   level_next = fifo_level - 1'b1;
            default: level_next = fifo_level;
        endcase
    end

    // Registered request-side ready and one-cycle-delayed occupancy.
    always_ff @(posedge clk_a) begin
        if (!reset_n) begin
            req_ready <= 1'b0;
            level_d   <= '0;
        end else begin
            req_ready <= (level_next < LW'(FIFO_DEPTH));
            level_d   <= fifo_level;
        end
    end

    // Issue FSM: load the head, hold it until both handshakes land or the timer expires.
    always_ff @(posedge clk_a) begin
        if (!reset_n) begin
            state       <= IDLE;
            axi_awvalid <= 1'b0;
            axi_awaddr  <= '0;
            axi_wdata   <= '0;
            axi_wstrb   <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            timer       <= '0;
            wr_done     <= 1'b0;
            err_timeout <= 1'b0;
            done_count  <= '0;
        end else begin
            wr_done     <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (head_ok) begin
                        axi_awaddr  <= head_req.addr;
                        axi_wdata   <= head_req.data;
                        axi_wstrb   <= head_req.strb;
                        axi_awvalid <= 1'b1;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        timer       <= '0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    aw_done <= aw_done | axi_awready;
                    w_done  <= w_done | axi_wready;
                    timer   <= timer + 1'b1;
                    if (complete) begin
                        axi_awvalid <= 1'b0;
                        wr_done     <= 1'b1;
                        if (done_count != 16'hFFFF) begin
                            done_count <= done_count + 16'd1;
                        end
                        state <= IDLE;
                    end else if (timeout) begin
                        axi_awvalid <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
